// File: rtl/lsu_mem_if_if.sv
// Bus bundle between the load/store unit, the CPU request/response side and
// the byte-banked data memory.
//   master : the load/store unit (drives req_ready, resp_*, mem_* outputs)
//   slave  : the environment (CPU datapath and memory), drives req_* and mem_dataout
interface lsu_mem_if_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_raddress;
    logic [31:0] mem_waddress;
    logic [31:0] mem_datain;
    logic [3:0]  mem_wr;
    logic [31:0] mem_dataout;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dataout,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_raddress, mem_waddress, mem_datain, mem_wr
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dataout,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_raddress, mem_waddress, mem_datain, mem_wr
    );
endinterface

// File: rtl/lsu_mem_if.sv
// Load/store initiator for the byte-banked 32-bit data memory.
// Accepts one RISC-V load/store at a time, drives the memory's read/write
// address, write data and byte enables, captures read data after
// READ_LATENCY edges and returns a formatted load result or store completion.
// Ports:
//   Clk      : system clock, rising edge
//   Reset_n  : synchronous active-low reset
//   bus      : lsu_mem_if_if.master (request, response and memory signals)
module lsu_mem_if #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ADDR_BITS    = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    lsu_mem_if_if.master  bus
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned DW    = 32;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ_WAIT = 3'd2,
        RESP      = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_err_q, resp_err_d;
    logic [DW-1:0]      resp_rdata_q, resp_rdata_d;
    logic [DW-1:0]      raddr_q, raddr_d;
    logic [DW-1:0]      waddr_q, waddr_d;
    logic [DW-1:0]      datain_q, datain_d;
    logic [3:0]         wr_q, wr_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               addr_fault;
    logic               funct_fault;

    // Sign/zero extension of the raw memory word according to the load type.
    function automatic logic [DW-1:0] format_load(input logic [2:0] f3,
                                                  input logic [DW-1:0] d);
        logic [DW-1:0] r;
        case (f3)
            3'd0:    r = {{24{d[7]}}, d[7:0]};
            3'd1:    r = {{16{d[15]}}, d[15:0]};
            3'd2:    r = d;
            3'd4:    r = {24'd0, d[7:0]};
            3'd5:    r = {16'd0, d[15:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Byte enables; data is never shifted, so the low byte always sits in lane 0.
    function automatic logic [3:0] store_mask(input logic [2:0] f3);
        logic [3:0] m;
        case (f3)
            3'd0:    m = 4'b0001;
            3'd1:    m = 4'b0011;
            3'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Request qualification
    always_comb begin
        accept      = bus.req_valid & ready_q;
        addr_fault  = (bus.req_addr >> ADDR_BITS) != 32'd0;
        if (bus.req_we) begin
            funct_fault = bus.req_funct3 > 3'd2;
        end else begin
            funct_fault = (bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6) ||
                          (bus.req_funct3 == 3'd7);
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        raddr_d      = raddr_q;
        waddr_d      = waddr_q;
        datain_d     = datain_q;
        wr_d         = 4'b0000;
        funct3_d     = funct3_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (addr_fault || funct_fault) begin
                        state_d      = FAULT;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (bus.req_we) begin
                        // Store completes in the same cycle the enables are driven.
                        state_d      = WRITE;
                        waddr_d      = bus.req_addr;
                        datain_d     = bus.req_wdata;
                        wr_d         = store_mask(bus.req_funct3);
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d  = READ_WAIT;
                        raddr_d  = bus.req_addr;
                        funct3_d = bus.req_funct3;
                        cnt_d    = '0;
                    end
                end
            end
            READ_WAIT: begin
                // Count edges since the read address became stable.
                if (cnt_q == LAT_LAST) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = format_load(funct3_q, bus.mem_dataout);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WRITE:   state_d = IDLE;
            RESP:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            raddr_q      <= '0;
            waddr_q      <= '0;
            datain_q     <= '0;
            wr_q         <= 4'b0000;
            funct3_q     <= 3'd0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            raddr_q      <= raddr_d;
            waddr_q      <= waddr_d;
            datain_q     <= datain_d;
            wr_q         <= wr_d;
            funct3_q     <= funct3_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.req_ready    = ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_err     = resp_err_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.mem_raddress = raddr_q;
    assign bus.mem_waddress = waddr_q;
    assign bus.mem_datain   = datain_q;
    assign bus.mem_wr       = wr_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Testbench for lsu_mem_if: two instances (READ_LATENCY 1 and 3) share a
// byte-addressed memory model; expected responses are queued when a request
// is accepted and checked when resp_valid pulses.
module tb_lsu_mem_if;

    typedef struct {
        int          inst;
        int          exp_cyc;
        logic [31:0] rdata;
        logic        err;
        logic        is_store;
        logic        is_load;
        logic [3:0]  wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_a [2];
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready_a [2];
    logic        resp_valid_a [2];
    logic        resp_err_a [2];
    logic [31:0] resp_rdata_a [2];
    logic [31:0] raddr_a [2];
    logic [31:0] waddr_a [2];
    logic [31:0] datain_a [2];
    logic [3:0]  wr_a [2];
    logic [31:0] dataout_a [2];

    logic [7:0]  mem_b [0:65535];
    logic [31:0] seen [2];
    int          age [2];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    entry_t      sb [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        lsu_mem_if_if bus ();
        assign bus.req_valid   = req_valid_a[g];
        assign bus.req_we      = req_we;
        assign bus.req_funct3  = req_funct3;
        assign bus.req_addr    = req_addr;
        assign bus.req_wdata   = req_wdata;
        assign bus.mem_dataout = dataout_a[g];
        assign req_ready_a[g]  = bus.req_ready;
        assign resp_valid_a[g] = bus.resp_valid;
        assign resp_err_a[g]   = bus.resp_err;
        assign resp_rdata_a[g] = bus.resp_rdata;
        assign raddr_a[g]      = bus.mem_raddress;
        assign waddr_a[g]      = bus.mem_waddress;
        assign datain_a[g]     = bus.mem_datain;
        assign wr_a[g]         = bus.mem_wr;

        lsu_mem_if #(
            .READ_LATENCY ((g == 0) ? 1 : 3),
            .ADDR_BITS    (16)
        ) u_dut (
            .Clk     (clk),
            .Reset_n (rst_n),
            .bus     (bus.master)
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [3:0] mask_of(input logic [2:0] f3);
        return (f3 == 3'd0) ? 4'b0001 : (f3 == 3'd1) ? 4'b0011 : 4'b1111;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {mem_b[16'(a + 32'd3)], mem_b[16'(a + 32'd2)],
                mem_b[16'(a + 32'd1)], mem_b[16'(a)]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: byte writes at the clock edge; read data only valid once
    // the read address has been stable for READ_LATENCY-1 edges.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_a[i][k] === 1'b1) begin
                    mem_b[16'(waddr_a[i] + 32'(k))] = datain_a[i][8*k +: 8];
                end
            end
        end
        cyc++;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (raddr_a[i] !== seen[i]) begin
                seen[i] = raddr_a[i];
                age[i]  = 0;
            end else if (age[i] < 1000) begin
                age[i]++;
            end
            dataout_a[i] = (age[i] >= lat_of(i) - 1) ? rd_word(raddr_a[i]) : 32'hBAD0_BAD0;
        end
    end

    // Response monitor / scoreboard
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (resp_valid_a[i] === 1'b1) begin
                if (sb.size() != 0 && sb[0].inst == i) begin
                    entry_t e;
                    e = sb.pop_front();
                    check("resp_rdata", resp_rdata_a[i], e.rdata);
                    check("resp_err", 32'(resp_err_a[i]), 32'(e.err));
                    check("resp_cycle", 32'(cyc), 32'(e.exp_cyc));
                    if (e.is_store) begin
                        check("store_mem_wr", 32'(wr_a[i]), 32'(e.wr));
                        check("store_waddress", waddr_a[i], e.waddr);
                        check("store_datain", datain_a[i], e.wdata);
                    end else begin
                        check("resp_mem_wr_zero", 32'(wr_a[i]), 32'd0);
                    end
                    if (e.is_load) check("load_raddress", raddr_a[i], e.raddr);
                end else begin
                    check("spurious_resp", 32'(resp_valid_a[i]), 32'd0);
                end
            end else begin
                check("mem_wr_quiet", 32'(wr_a[i]), 32'd0);
            end
        end
    end

    // Present a request and hold it until accepted; returns the cycle T of acceptance.
    task automatic do_req(input int inst, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input bit push, output int rdy_cyc);
        entry_t e;
        bit     got;
        @(negedge clk);
        req_we            = we;
        req_funct3        = f3;
        req_addr          = addr;
        req_wdata         = wdata;
        req_valid_a[inst] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (req_ready_a[inst] === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_timeout", 32'(got), 32'd1);
        rdy_cyc    = cyc;
        e.inst     = inst;
        e.rdata    = exp_rdata;
        e.err      = exp_err;
        e.is_store = 1'b0;
        e.is_load  = 1'b0;
        e.wr       = 4'b0000;
        e.waddr    = addr;
        e.wdata    = wdata;
        e.raddr    = addr;
        if (exp_err || we) begin
            e.exp_cyc  = cyc + 1;
            e.is_store = we && !exp_err;
            e.wr       = mask_of(f3);
        end else begin
            e.exp_cyc = cyc + 1 + lat_of(inst);
            e.is_load = 1'b1;
        end
        if (got && push) sb.push_back(e);
        @(posedge clk);
    endtask

    // Drop valid just after the accepting edge and scramble the fields.
    task automatic req_idle();
        #1;
        req_valid_a[0] = 1'b0;
        req_valid_a[1] = 1'b0;
        req_we         = 1'($urandom);
        req_funct3     = 3'($urandom);
        req_addr       = $urandom;
        req_wdata      = $urandom;
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic op(input int inst, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
        int rc;
        do_req(inst, we, f3, addr, wdata, exp_rdata, exp_err, 1'b1, rc);
        req_idle();
        drain();
    endtask

    initial begin
        int rc;
        int rc2;
        for (int a = 0; a < 65536; a++) mem_b[a] = 8'h00;
        seen[0] = '0; seen[1] = '0; age[0] = 0; age[1] = 0;
        dataout_a[0] = '0; dataout_a[1] = '0;

        // Reset held 3 cycles with a valid request pending
        rst_n          = 1'b0;
        req_valid_a[0] = 1'b1;
        req_valid_a[1] = 1'b1;
        req_we         = 1'b0;
        req_funct3     = 3'd2;
        req_addr       = 32'h10;
        req_wdata      = 32'h0;
        repeat (3) begin
            @(negedge clk);
            check("ready_in_reset_0", 32'(req_ready_a[0]), 32'd0);
            check("ready_in_reset_1", 32'(req_ready_a[1]), 32'd0);
        end
        rst_n          = 1'b1;
        req_valid_a[0] = 1'b0;
        req_valid_a[1] = 1'b0;
        @(negedge clk);
        check("ready_after_reset_0", 32'(req_ready_a[0]), 32'd1);
        check("ready_after_reset_1", 32'(req_ready_a[1]), 32'd1);

        // READ_LATENCY=1 instance: stores, loads, formatting, misalignment
        op(0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        op(0, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        op(0, 1'b1, 3'd0, 32'h20, 32'h1234_5680, 32'h0, 1'b0);
        op(0, 1'b0, 3'd0, 32'h20, 32'h0, 32'hFFFF_FF80, 1'b0);
        op(0, 1'b0, 3'd4, 32'h20, 32'h0, 32'h0000_0080, 1'b0);
        op(0, 1'b1, 3'd1, 32'h22, 32'hAAAA_8001, 32'h0, 1'b0);
        op(0, 1'b0, 3'd1, 32'h22, 32'h0, 32'hFFFF_8001, 1'b0);
        op(0, 1'b0, 3'd5, 32'h22, 32'h0, 32'h0000_8001, 1'b0);
        op(0, 1'b0, 3'd2, 32'h20, 32'h0, 32'h8001_0080, 1'b0);
        op(0, 1'b0, 3'd2, 32'h11, 32'h0, 32'h00DE_ADBE, 1'b0);

        // Faults: out-of-range address, illegal store/load funct3
        op(0, 1'b0, 3'd2, 32'h0001_0000, 32'h0, 32'h0, 1'b1);
        op(0, 1'b1, 3'd3, 32'h30, 32'hFFFF_FFFF, 32'h0, 1'b1);
        op(0, 1'b0, 3'd6, 32'h10, 32'h0, 32'h0, 1'b1);
        op(0, 1'b0, 3'd2, 32'h30, 32'h0, 32'h0, 1'b0);

        // READ_LATENCY=3 instance with a second request held during the load
        do_req(1, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, rc);
        do_req(1, 1'b0, 3'd5, 32'h22, 32'h0, 32'h0000_8001, 1'b0, 1'b1, rc2);
        req_idle();
        check("b2b_ready_cycle", 32'(rc2), 32'(rc + 5));
        drain();

        // Reset during READ_WAIT: request dropped, no response
        do_req(1, 1'b0, 3'd2, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, rc);
        req_idle();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("ready_mid_reset", 32'(req_ready_a[1]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_mid_reset", 32'(req_ready_a[1]), 32'd1);
        repeat (6) @(negedge clk);
        op(1, 1'b0, 3'd0, 32'h23, 32'h0, 32'hFFFF_FF80, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
